// File: rtl/serial_rx_param_if.sv
// Receiver-side bundle: the serial line in, the character strobe and status flags out.
interface serial_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 new_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 busy;

  modport master (
    input  rx,
    output data, new_data, parity_err, frame_err, break_det, busy
  );

  modport slave (
    output rx,
    input  data, new_data, parity_err, frame_err, break_det, busy
  );
endinterface

// File: rtl/serial_rx_param.sv
// Parametrised UART receiver: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits,
// with start-glitch rejection and parity/framing/break reporting on a one-cycle strobe.
module serial_rx_param #(
  parameter int CLK_PER_BIT = 50,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input logic               clk,
  input logic               rst,
  serial_rx_param_if.master bus
);
  localparam int              CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]   FULL_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        cyc_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_bad;

  logic [DATA_BITS-1:0] data_q;
  logic                 new_data_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 break_q;
  logic                 busy_q;

  logic                 frame_bad;
  logic                 par_xor;
  logic                 par_err_calc;
  logic                 break_calc;

  // Status of the character as it would be delivered if this were the final stop sample.
  always_comb begin
    frame_bad    = stop_bad | ~rx_s;
    par_xor      = (^shift) ^ par_bit;
    par_err_calc = 1'b0;
    if (PARITY == 1) par_err_calc = par_xor;
    if (PARITY == 2) par_err_calc = ~par_xor;
    break_calc   = (shift == '0) && ((PARITY == 0) || !par_bit) && frame_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cyc_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      stop_bad     <= 1'b0;
      data_q       <= '0;
      new_data_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta    <= bus.rx;
      rx_s       <= rx_meta;
      new_data_q <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt  <= '0;
          bit_cnt  <= '0;
          stop_bad <= 1'b0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        // A start bit that is high again at mid-bit was a glitch: drop it silently.
        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DATA: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        PAR: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        // A bad stop bit parks us in WAIT_HIGH so a held-low line yields one character only.
        STOP: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt      <= '0;
              data_q       <= shift;
              parity_err_q <= par_err_calc;
              frame_err_q  <= frame_bad;
              break_q      <= break_calc;
              new_data_q   <= 1'b1;
              if (frame_bad) begin
                state <= WAIT_HIGH;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              stop_bad <= frame_bad;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.new_data   = new_data_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.break_det  = break_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: three receivers (8N1, 8E1, 7O2) driven by bit-level frames and
// compared against a character-level model of what each frame should deliver and when.
`timescale 1ns/1ps
module tb_serial_rx_param;
  localparam int N = 50;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic        bd;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line [3];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  rec_t q [3][$];
  rec_t last [3];

  serial_rx_param_if #(.DATA_BITS(8)) if0 ();
  serial_rx_param_if #(.DATA_BITS(8)) if1 ();
  serial_rx_param_if #(.DATA_BITS(7)) if2 ();

  assign if0.rx = rx_line[0];
  assign if1.rx = rx_line[1];
  assign if2.rx = rx_line[2];

  serial_rx_param #(.CLK_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  serial_rx_param #(.CLK_PER_BIT(N), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  serial_rx_param #(.CLK_PER_BIT(N), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe capture: every delivered character lands in its receiver's queue with its cycle.
  always @(negedge clk) begin
    if (if0.new_data === 1'b1)
      q[0].push_back({32'(cyc), 9'(if0.data), if0.parity_err, if0.frame_err, if0.break_det});
    if (if1.new_data === 1'b1)
      q[1].push_back({32'(cyc), 9'(if1.data), if1.parity_err, if1.frame_err, if1.break_det});
    if (if2.new_data === 1'b1)
      q[2].push_back({32'(cyc), 9'(if2.data), if2.parity_err, if2.frame_err, if2.break_det});
  end

  function automatic int db(input int w);
    return (w == 2) ? 7 : 8;
  endfunction

  function automatic int par(input int w);
    return w;
  endfunction

  function automatic int sb(input int w);
    return (w == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask(input int w);
    return 9'((1 << db(w)) - 1);
  endfunction

  // {data, parity_err, frame_err, break_det, new_data, busy}
  function automatic logic [13:0] outs(input int w);
    case (w)
      0:       return {9'(if0.data), if0.parity_err, if0.frame_err, if0.break_det, if0.new_data, if0.busy};
      1:       return {9'(if1.data), if1.parity_err, if1.frame_err, if1.break_det, if1.new_data, if1.busy};
      default: return {9'(if2.data), if2.parity_err, if2.frame_err, if2.break_det, if2.new_data, if2.busy};
    endcase
  endfunction

  function automatic logic good_par(input int w, input logic [8:0] d);
    int ones;
    ones = $countones(d & mask(w));
    return (par(w) == 1) ? logic'(ones % 2) : logic'(ones % 2 == 0);
  endfunction

  // Character-level expectation for a frame whose start bit was put on the line in cycle t.
  function automatic rec_t model(input int w, input logic [8:0] d, input logic pbit,
                                 input logic [1:0] stops, input int t);
    rec_t r;
    int   f;
    int   ones;
    f      = 1 + db(w) + ((par(w) != 0) ? 1 : 0) + sb(w);
    r.cyc  = 32'(t + 2 + N / 2 + (f - 1) * N + 1);
    r.data = d & mask(w);
    ones   = $countones(r.data) + ((par(w) != 0) ? int'(pbit) : 0);
    r.pe   = (par(w) == 1) ? logic'(ones % 2 == 1) :
             (par(w) == 2) ? logic'(ones % 2 == 0) : 1'b0;
    r.fe   = (sb(w) == 1) ? !stops[0] : !(stops[0] && stops[1]);
    r.bd   = r.fe && (r.data == 9'd0) && ((par(w) == 0) || !pbit);
    return r;
  endfunction

  task automatic send_frame(input int w, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops, output int t);
    logic [15:0] bits;
    int          n;
    bits = '1;
    n    = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < db(w); i++) begin bits[n] = d[i]; n++; end
    if (par(w) != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < sb(w); i++) begin bits[n] = stops[i]; n++; end
    t = cyc;
    for (int i = 0; i < n; i++) begin
      rx_line[w] = bits[i];
      repeat (N) @(posedge clk);
      #1;
    end
    rx_line[w] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      tests++;
      if (outs(w) !== 14'd0) begin
        fails++;
        $display("[TB] FAIL reset_outs[%0d] got %h want 0", w, outs(w));
      end
      last[w] = '0;
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1_a5();
    int   t;
    rec_t got, exp;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, t);
    exp = model(0, 9'h0A5, 1'b0, 2'b11, t);
    repeat (N) @(negedge clk);
    tests++;
    if (q[0].size() !== 1) begin
      fails++;
      $display("[TB] FAIL a5_strobes got %0d want 1", q[0].size());
    end
    if (q[0].size() > 0) begin
      got = q[0].pop_front();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL a5_char got cyc=%0d d=%h pe=%b fe=%b bd=%b want cyc=%0d d=%h pe=%b fe=%b bd=%b",
                 got.cyc, got.data, got.pe, got.fe, got.bd, exp.cyc, exp.data, exp.pe, exp.fe, exp.bd);
      end
      last[0] = exp;
    end
    q[0].delete();
  endtask

  task automatic test_parity();
    int   t;
    rec_t got, exp;
    logic pb [2];
    pb[0] = 1'b0;
    pb[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_frame(1, 9'h037, pb[k], 2'b11, t);
      exp = model(1, 9'h037, pb[k], 2'b11, t);
      repeat (N) @(negedge clk);
      tests++;
      if (q[1].size() !== 1) begin
        fails++;
        $display("[TB] FAIL parity_strobes[%0d] got %0d want 1", k, q[1].size());
      end
      if (q[1].size() > 0) begin
        got = q[1].pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("[TB] FAIL parity_char[%0d] got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                   k, got.cyc, got.data, got.pe, got.fe, exp.cyc, exp.data, exp.pe, exp.fe);
        end
        last[1] = exp;
      end
      q[1].delete();
    end
  endtask

  task automatic test_7o2_frame();
    int   t;
    rec_t got, exp;
    send_frame(2, 9'h041, 1'b1, 2'b01, t);
    exp = model(2, 9'h041, 1'b1, 2'b01, t);
    rx_line[2] = 1'b0;
    repeat (2 * N) @(negedge clk);
    tests++;
    if (outs(2)[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wait_high_busy got %b want 1", outs(2)[0]);
    end
    rx_line[2] = 1'b1;
    repeat (3 * N) @(negedge clk);
    tests++;
    if (q[2].size() !== 1) begin
      fails++;
      $display("[TB] FAIL 7o2_strobes got %0d want 1", q[2].size());
    end
    tests++;
    if (outs(2)[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL 7o2_busy_after got %b want 0", outs(2)[0]);
    end
    if (q[2].size() > 0) begin
      got = q[2].pop_front();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL 7o2_char got cyc=%0d d=%h pe=%b fe=%b bd=%b want cyc=%0d d=%h pe=%b fe=%b bd=%b",
                 got.cyc, got.data, got.pe, got.fe, got.bd, exp.cyc, exp.data, exp.pe, exp.fe, exp.bd);
      end
      last[2] = exp;
    end
    q[2].delete();
  endtask

  task automatic test_break();
    int   t;
    rec_t got, exp;
    @(negedge clk);
    t = cyc;
    rx_line[0] = 1'b0;
    repeat (16 * N) @(negedge clk);
    tests++;
    if (outs(0)[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL break_busy_low got %b want 1", outs(0)[0]);
    end
    repeat (4 * N) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (outs(0)[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL break_busy_release got %b want 0", outs(0)[0]);
    end
    exp = model(0, 9'h000, 1'b0, 2'b00, t);
    tests++;
    if (q[0].size() !== 1) begin
      fails++;
      $display("[TB] FAIL break_strobes got %0d want 1", q[0].size());
    end
    if (q[0].size() > 0) begin
      got = q[0].pop_front();
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL break_char got cyc=%0d d=%h fe=%b bd=%b want cyc=%0d d=%h fe=%b bd=%b",
                 got.cyc, got.data, got.fe, got.bd, exp.cyc, exp.data, exp.fe, exp.bd);
      end
      last[0] = exp;
    end
    q[0].delete();
  endtask

  task automatic test_glitch();
    int busy_cycles;
    busy_cycles = 0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 90; i++) begin
      if (i == 0)  rx_line[0] = 1'b0;
      if (i == 10) rx_line[0] = 1'b1;
      if (outs(0)[0] === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    tests++;
    if (busy_cycles !== N / 2) begin
      fails++;
      $display("[TB] FAIL glitch_busy_cycles got %0d want %0d", busy_cycles, N / 2);
    end
    tests++;
    if (q[0].size() !== 0) begin
      fails++;
      $display("[TB] FAIL glitch_strobes got %0d want 0", q[0].size());
    end
    tests++;
    if (outs(0)[13:2] !== {last[0].data, last[0].pe, last[0].fe, last[0].bd}) begin
      fails++;
      $display("[TB] FAIL glitch_outputs got %h want %h", outs(0)[13:2],
               {last[0].data, last[0].pe, last[0].fe, last[0].bd});
    end
    q[0].delete();
  endtask

  task automatic test_random();
    int         t;
    int         gap;
    rec_t       got, exp;
    logic [8:0] d;
    logic       pb;
    logic [1:0] st;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 6; k++) begin
        d  = 9'($urandom) & mask(w);
        pb = good_par(w, d) ^ logic'($urandom_range(0, 3) == 0);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        if (sb(w) == 1) st[1] = 1'b1;
        send_frame(w, d, pb, st, t);
        exp = model(w, d, pb, st, t);
        tests++;
        if (q[w].size() !== 1) begin
          fails++;
          $display("[TB] FAIL rand_strobes[%0d.%0d] got %0d want 1", w, k, q[w].size());
        end
        if (q[w].size() > 0) begin
          got = q[w].pop_front();
          tests++;
          if (got !== exp) begin
            fails++;
            $display("[TB] FAIL rand_char[%0d.%0d] got cyc=%0d d=%h pe=%b fe=%b bd=%b want cyc=%0d d=%h pe=%b fe=%b bd=%b",
                     w, k, got.cyc, got.data, got.pe, got.fe, got.bd,
                     exp.cyc, exp.data, exp.pe, exp.fe, exp.bd);
          end
          last[w] = exp;
        end
        q[w].delete();
        gap = exp.fe ? N + int'($urandom_range(0, N)) : int'($urandom_range(0, N));
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int   t, t1, t2;
    rec_t got1, got2, exp1, exp2;
    send_frame(0, 9'h05A, 1'b0, 2'b11, t);
    repeat (N) @(negedge clk);
    q[0].delete();
    rx_line[0] = 1'b0;
    repeat (4 * N + 20) @(negedge clk);
    rst        = 1'b1;
    rx_line[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (outs(0) !== 14'd0) begin
      fails++;
      $display("[TB] FAIL midframe_reset_outs got %h want 0", outs(0));
    end
    for (int w = 0; w < 3; w++) last[w] = '0;
    repeat (12 * N) @(negedge clk);
    tests++;
    if (q[0].size() !== 0) begin
      fails++;
      $display("[TB] FAIL midframe_reset_strobes got %0d want 0", q[0].size());
    end
    send_frame(0, 9'h012, 1'b0, 2'b11, t1);
    send_frame(0, 9'h034, 1'b0, 2'b11, t2);
    exp1 = model(0, 9'h012, 1'b0, 2'b11, t1);
    exp2 = model(0, 9'h034, 1'b0, 2'b11, t2);
    repeat (N) @(negedge clk);
    tests++;
    if (q[0].size() !== 2) begin
      fails++;
      $display("[TB] FAIL b2b_strobes got %0d want 2", q[0].size());
    end
    if (q[0].size() >= 2) begin
      got1 = q[0].pop_front();
      got2 = q[0].pop_front();
      tests++;
      if (got1 !== exp1) begin
        fails++;
        $display("[TB] FAIL b2b_first got cyc=%0d d=%h want cyc=%0d d=%h",
                 got1.cyc, got1.data, exp1.cyc, exp1.data);
      end
      tests++;
      if (got2 !== exp2) begin
        fails++;
        $display("[TB] FAIL b2b_second got cyc=%0d d=%h want cyc=%0d d=%h",
                 got2.cyc, got2.data, exp2.cyc, exp2.data);
      end
      tests++;
      if (int'(got2.cyc - got1.cyc) !== 10 * N) begin
        fails++;
        $display("[TB] FAIL b2b_spacing got %0d want %0d", int'(got2.cyc - got1.cyc), 10 * N);
      end
    end
    q[0].delete();
  endtask

  initial begin
    for (int w = 0; w < 3; w++) rx_line[w] = 1'b1;
    test_reset();
    test_8n1_a5();
    test_parity();
    test_7o2_frame();
    test_break();
    test_glitch();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
